// File: rtl/decode_rx.sv
// rtl/decode_rx.sv - USB full-speed receive line decoder (NRZI, unstuffing, SYNC/EOP, byte assembly)
module decode_rx (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dplus_in,
  input  logic       dminus_in,
  input  logic       bit_strobe,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_eop,
  output logic       rx_error,
  output logic       rx_active
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP1, S_EOP2, S_ERR} state_t;

  logic       dp_meta_q, dp_q, dm_meta_q, dm_q;
  state_t     state_q, state_d;
  logic       prev_q, prev_d;
  logic       se0_prev_q, se0_prev_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [2:0] idle_q, idle_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d, eop_q, eop_d, err_q, err_d;

  logic       line_j, line_k, line_se0, line_se1, dec_bit;
  logic [7:0] byte_w;

  // Synchronizers reset to the idle J state (D+=1, D-=0)
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta_q <= 1'b1;
      dp_q      <= 1'b1;
      dm_meta_q <= 1'b0;
      dm_q      <= 1'b0;
    end else begin
      dp_meta_q <= dplus_in;
      dp_q      <= dp_meta_q;
      dm_meta_q <= dminus_in;
      dm_q      <= dm_meta_q;
    end
  end

  assign line_j   =  dp_q & ~dm_q;
  assign line_k   = ~dp_q &  dm_q;
  assign line_se0 = ~dp_q & ~dm_q;
  assign line_se1 =  dp_q &  dm_q;
  // prev_q holds the D+ level of the last J/K sample: 1 means J
  assign dec_bit  = (dp_q == prev_q);
  assign byte_w   = {dec_bit, shift_q};

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    se0_prev_d = se0_prev_q;
    ones_d     = ones_q;
    bitcnt_d   = bitcnt_q;
    idle_d     = idle_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;
    if (bit_strobe) begin
      se0_prev_d = line_se0;
      case (state_q)
        S_IDLE: begin
          prev_d = 1'b1;
          if (line_k) begin
            state_d  = S_SYNC;
            prev_d   = 1'b0;
            ones_d   = 3'd0;
            bitcnt_d = 3'd1;
            shift_d  = {1'b0, shift_q[6:1]};
          end
        end
        S_SYNC, S_DATA: begin
          if (line_se1 || (line_se0 && (state_q == S_SYNC || bitcnt_q != 3'd0))) begin
            err_d = 1'b1;
          end else if (line_se0) begin
            state_d = S_EOP1;
          end else begin
            prev_d = dp_q;
            if (ones_q == 3'd6) begin
              // A 1 after six 1s is a stuff violation; a 0 is the stuff bit itself
              if (dec_bit) err_d = 1'b1;
              else         ones_d = 3'd0;
            end else begin
              ones_d   = dec_bit ? ones_q + 3'd1 : 3'd0;
              shift_d  = byte_w[7:1];
              bitcnt_d = bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                if (state_q == S_SYNC) begin
                  if (byte_w == 8'h80) state_d = S_DATA;
                  else                 err_d   = 1'b1;
                end else begin
                  data_d  = byte_w;
                  valid_d = 1'b1;
                end
              end
            end
          end
        end
        S_EOP1: begin
          if (line_se0) state_d = S_EOP2;
          else          err_d   = 1'b1;
        end
        S_EOP2: begin
          if (line_j) begin
            eop_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
        S_ERR: begin
          if (line_j) begin
            if (se0_prev_q || idle_q == 3'd7) state_d = S_IDLE;
            else                              idle_d  = idle_q + 3'd1;
          end else begin
            idle_d = 3'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (err_d) begin
        state_d = S_ERR;
        idle_d  = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      prev_q     <= 1'b1;
      se0_prev_q <= 1'b0;
      ones_q     <= 3'd0;
      bitcnt_q   <= 3'd0;
      idle_q     <= 3'd0;
      shift_q    <= 7'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      se0_prev_q <= se0_prev_d;
      ones_q     <= ones_d;
      bitcnt_q   <= bitcnt_d;
      idle_q     <= idle_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_eop        = eop_q;
  assign rx_error      = err_q;
  assign rx_active     = (state_q != S_IDLE);

endmodule
